prog_launcher: RTL

- Host-side sequencer for the processor's Start/Ack handshake; it is the initiator that drives Start and consumes Ack.
- On a Go request it launches programs 0..NUM_PROGS-1 back to back. For each program it pulses Start, waits for Ack, and measures cycles to completion.
- Sits beside the processor top level in the bench and on the FPGA wrapper. Replaces hand-written Start/Ack sequencing in test benches.

---
 rtl/prog_launcher.sv | 110 +++++++++++
 1 files changed

// File: rtl/prog_launcher.sv
// Host-side launcher for the processor Start/Ack handshake.
// Runs programs 0..NUM_PROGS-1 back to back and times each one from Start falling to Ack.
module prog_launcher #(
    parameter int          NUM_PROGS = 3,
    parameter int          START_LEN = 2,
    parameter int          CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 60000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             Abort,
    input  logic             Ack,
    output logic             Start,
    output logic [1:0]       ProgIdx,
    output logic [CNT_W-1:0] CycleCount,
    output logic             CountValid,
    output logic             Busy,
    output logic             Done,
    output logic             TimedOut
);

    localparam int LW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam logic [LW-1:0]    LAUNCH_LAST = LW'(START_LEN - 1);
    localparam logic [1:0]       PROG_LAST   = 2'(NUM_PROGS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, RECORD, DONE} state_t;

    state_t           state, nextState;
    logic [LW-1:0]    launchCnt;
    logic [CNT_W-1:0] runCnt;
    logic             ackSeenLow;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Go) nextState = LAUNCH;
            LAUNCH:  if (launchCnt == LAUNCH_LAST) nextState = RUN;
            RUN: begin
                // An Ack only counts once it has been seen low during this launch.
                if (Ack && ackSeenLow)        nextState = RECORD;
                else if (runCnt == TIMEOUT_CNT) nextState = DONE;
            end
            RECORD:  nextState = (ProgIdx == PROG_LAST) ? DONE : LAUNCH;
            DONE:    if (Go) nextState = LAUNCH;
            default: nextState = IDLE;
        endcase
        if (Abort) nextState = IDLE;
    end

    // Flags are registered off nextState so they line up with the state they describe.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            Start      <= 1'b0;
            CountValid <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state      <= nextState;
            Start      <= (nextState == LAUNCH);
            CountValid <= (nextState == RECORD);
            Busy       <= (nextState == LAUNCH) || (nextState == RUN) || (nextState == RECORD);
            Done       <= (nextState == DONE);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            launchCnt  <= '0;
            runCnt     <= '0;
            ackSeenLow <= 1'b0;
            ProgIdx    <= '0;
            CycleCount <= '0;
            TimedOut   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (nextState == LAUNCH) begin
                        ProgIdx    <= '0;
                        TimedOut   <= 1'b0;
                        launchCnt  <= '0;
                        ackSeenLow <= 1'b0;
                    end
                end
                LAUNCH: begin
                    launchCnt <= launchCnt + 1'b1;
                    if (!Ack) ackSeenLow <= 1'b1;
                    if (nextState == RUN) runCnt <= '0;
                end
                RUN: begin
                    if (!Ack) ackSeenLow <= 1'b1;
                    if (nextState == RECORD)    CycleCount <= runCnt;
                    else if (nextState == DONE) TimedOut   <= 1'b1;
                    else if (nextState == RUN)  runCnt     <= runCnt + 1'b1;
                end
                RECORD: begin
                    if (nextState == LAUNCH) begin
                        ProgIdx    <= ProgIdx + 2'd1;
                        launchCnt  <= '0;
                        ackSeenLow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
